oam_dma_arbiter: RTL and testbench

- Bus arbiter and sequencer that shares the cpu6502 external bus with a page-copy DMA engine, in the style of the NES sprite DMA.
- A CPU write to the trigger address latches a source page. The block then halts the core via RDY and takes the bus to copy XFER_LEN bytes from page<<8 to a fixed destination register.
- It sits between cpu6502 (addr/odata/rw) and the system bus (rom, ram, peripherals).

---
 rtl/cpu6502_bus_pkg.sv | 19 +
 rtl/oam_dma_arbiter_if.sv | 25 ++
 rtl/dma_bus_mux.sv | 37 +++
 rtl/oam_dma_arbiter.sv | 98 +++++++++
 tb/tb_oam_dma_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu6502_bus_pkg.sv
// Shared cpu6502 bus definitions: DMA state encoding,
// rw levels and default peripheral addresses.
package cpu6502_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] TRIGGER_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and system-bus-side signals of the DMA arbiter.
// master = arbiter, slave = surrounding cpu/bus fabric.
interface oam_dma_arbiter_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_odata;
  logic        bus_rw;
  logic [7:0]  bus_idata;
  logic        dma_busy;

  modport master (
    input  cpu_addr, cpu_odata, cpu_rw, bus_idata,
    output cpu_rdy, bus_addr, bus_odata, bus_rw, dma_busy
  );

  modport slave (
    output cpu_addr, cpu_odata, cpu_rw, bus_idata,
    input  cpu_rdy, bus_addr, bus_odata, bus_rw, dma_busy
  );

endinterface

// File: rtl/dma_bus_mux.sv
// Combinational bus source select: CPU passthrough,
// DMA source read, or DMA destination write.
module dma_bus_mux
  import cpu6502_bus_pkg::*;
#(
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
  input  dma_state_t  state,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [15:0] src_addr,
  input  logic [7:0]  latch,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw
);

  always_comb begin
    bus_addr  = cpu_addr;
    bus_odata = cpu_odata;
    bus_rw    = cpu_rw;
    unique case (1'b1)
      (state == ST_READ): begin
        bus_addr = src_addr;
        bus_rw   = RW_READ;
      end
      (state == ST_WRITE): begin
        bus_addr  = DEST_ADDR;
        bus_odata = latch;
        bus_rw    = RW_WRITE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Sprite-style page DMA: halts cpu6502 via RDY and copies
// one source page to a fixed destination register.
module oam_dma_arbiter
  import cpu6502_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = TRIGGER_ADDR_DEF,
  parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF,
  parameter int          XFER_LEN     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cyc_en,
  oam_dma_arbiter_if.master bus
);

  localparam int IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(XFER_LEN - 1);

  dma_state_t    state, state_n;
  logic [7:0]    page, page_n;
  logic [7:0]    latch, latch_n;
  logic [IW-1:0] idx, idx_n;
  logic          parity, parity_n;
  logic          trig;

  assign trig = (bus.cpu_rw == RW_WRITE)
             && (bus.cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      page   <= '0;
      idx    <= '0;
      latch  <= '0;
      parity <= 1'b0;
    end else begin
      state  <= state_n;
      page   <= page_n;
      idx    <= idx_n;
      latch  <= latch_n;
      parity <= parity_n;
    end
  end

  always_comb begin
    state_n  = state;
    page_n   = page;
    idx_n    = idx;
    latch_n  = latch;
    parity_n = parity;
    if (cyc_en) begin
      parity_n = ~parity;
      unique case (state)
        ST_IDLE: begin
          if (trig) begin
            page_n  = bus.cpu_odata;
            state_n = ST_HALT;
          end
        end
        // parity is odd now, so next cycle is even: read directly
        ST_HALT:  state_n = parity ? ST_READ : ST_ALIGN;
        ST_ALIGN: state_n = ST_READ;
        ST_READ: begin
          latch_n = bus.bus_idata;
          state_n = ST_WRITE;
        end
        ST_WRITE: begin
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = ST_IDLE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = ST_READ;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdy  = (state == ST_IDLE);
  assign bus.dma_busy = (state != ST_IDLE);

  dma_bus_mux #(
    .DEST_ADDR (DEST_ADDR)
  ) u_mux (
    .state     (state),
    .cpu_addr  (bus.cpu_addr),
    .cpu_odata (bus.cpu_odata),
    .cpu_rw    (bus.cpu_rw),
    .src_addr  ({page, 8'(idx)}),
    .latch     (latch),
    .bus_addr  (bus.bus_addr),
    .bus_odata (bus.bus_odata),
    .bus_rw    (bus.bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: passthrough, aligned and
// unaligned transfers, cyc_en gaps, re-trigger and reset abort.
module tb_oam_dma_arbiter;

  localparam int XL = 256;

  logic clk;
  logic reset;
  logic cyc_en;
  int   errs;
  int   checks;
  bit   par;

  oam_dma_arbiter_if bif ();

  oam_dma_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .cyc_en (cyc_en),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign bif.bus_idata = src_byte(bif.bus_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (cyc_en && reset) par = ~par;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bif.cpu_addr  = 16'h8000;
    bif.cpu_rw    = 1'b1;
    bif.cpu_odata = 8'h00;
  endtask

  task automatic align_to(input bit p);
    cpu_idle();
    while (par != p) tick();
  endtask

  task automatic xfer(input logic [7:0] pg,
                      input int gap_at,
                      input int abort_idx);
    int k, o, j, bad, gap, guard, tot, last_k;
    bit al, ce, gapped;
    logic [7:0]  i8;
    logic [15:0] ea, held;
    logic [7:0]  ed;
    logic        er;
    al = par;
    o = al ? 2 : 1;
    tot = o + 2 * XL;
    bif.cpu_addr  = 16'h4014;
    bif.cpu_rw    = 1'b0;
    bif.cpu_odata = pg;
    #1;
    check("trig_rdy", bif.cpu_rdy, 1);
    check("trig_pass", bif.bus_addr, 16'h4014);
    tick();
    k = 0; bad = 0; gap = 0; guard = 0;
    last_k = -1; gapped = 0; held = '0;
    while (bif.cpu_rdy !== 1'b1 && guard < 4000) begin
      guard++;
      if (k < o) begin
        ea = bif.cpu_addr; er = bif.cpu_rw; ed = bif.cpu_odata;
      end else begin
        j  = k - o;
        i8 = 8'(j >> 1);
        if (j % 2 == 0) begin
          ea = {pg, i8}; er = 1'b1; ed = bif.cpu_odata;
        end else begin
          ea = 16'h2004; er = 1'b0; ed = src_byte({pg, i8});
        end
      end
      if (bif.bus_addr !== ea || bif.bus_rw !== er ||
          bif.bus_odata !== ed || bif.dma_busy !== 1'b1)
        bad++;
      if (k != last_k) begin
        last_k = k;
        if (k == 0) begin
          check("halt_busy", bif.dma_busy, 1);
          check("halt_pass", bif.bus_addr, bif.cpu_addr);
        end
        if (al && k == 1)
          check("align_pass", bif.bus_addr, bif.cpu_addr);
        if (k == o) begin
          check("rd0_addr", bif.bus_addr, {pg, 8'h00});
          check("rd0_rw", bif.bus_rw, 1);
        end
        if (k == o + 1) begin
          check("wr0_addr", bif.bus_addr, 16'h2004);
          check("wr0_data", bif.bus_odata, src_byte({pg, 8'h00}));
        end
        if (k == o + 2 * XL - 2)
          check("rdl_addr", bif.bus_addr, {pg, 8'hFF});
        if (k == o + 2 * XL - 1)
          check("wrl_data", bif.bus_odata, src_byte({pg, 8'hFF}));
      end
      if (abort_idx >= 0 && k == o + 2 * abort_idx + 1) begin
        check("abort_wr", bif.bus_addr, 16'h2004);
        reset = 1'b0;
        #1;
        check("abort_rdy", bif.cpu_rdy, 1);
        check("abort_busy", bif.dma_busy, 0);
        check("abort_pass", bif.bus_addr, bif.cpu_addr);
        check("abort_bad", bad, 0);
        #1;
        reset = 1'b1;
        par = 1'b0;
        cpu_idle();
        return;
      end
      if (gap == 0 && !gapped && gap_at >= 0 && k == gap_at) begin
        gap = 3; gapped = 1; held = bif.bus_addr;
      end
      cyc_en = (gap == 0);
      ce = cyc_en;
      tick();
      if (ce) k++;
      if (gap > 0) begin
        gap--;
        if (gap == 0) check("gap_hold", bif.bus_addr, held);
      end
    end
    cyc_en = 1'b1;
    check("stall_cnt", k, tot);
    check("end_rdy", bif.cpu_rdy, 1);
    check("end_busy", bif.dma_busy, 0);
    check("seq_bad", bad, 0);
    cpu_idle();
    #1;
    check("idle_pass", bif.bus_addr, 16'h8000);
    tick();
  endtask

  initial begin
    errs = 0; checks = 0; par = 1'b0;
    reset = 1'b0;
    cyc_en = 1'b1;
    bif.cpu_addr  = 16'h1234;
    bif.cpu_rw    = 1'b1;
    bif.cpu_odata = 8'h5A;
    #3;
    check("rst_rdy", bif.cpu_rdy, 1);
    check("rst_busy", bif.dma_busy, 0);
    check("rst_addr", bif.bus_addr, 16'h1234);
    check("rst_rw", bif.bus_rw, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    par = 1'b0;

    bif.cpu_addr = 16'h0000; bif.cpu_rw = 1'b1; bif.cpu_odata = 8'h33;
    #1;
    check("pt_rd_addr", bif.bus_addr, 16'h0000);
    check("pt_rd_rw", bif.bus_rw, 1);
    check("pt_rd_rdy", bif.cpu_rdy, 1);
    tick();
    bif.cpu_addr = 16'h0080; bif.cpu_rw = 1'b0; bif.cpu_odata = 8'h01;
    #1;
    check("pt_wr_addr", bif.bus_addr, 16'h0080);
    check("pt_wr_rw", bif.bus_rw, 0);
    check("pt_wr_data", bif.bus_odata, 8'h01);
    check("pt_wr_busy", bif.dma_busy, 0);
    tick();

    align_to(1'b0);
    xfer(8'h02, -1, -1);
    align_to(1'b1);
    xfer(8'h02, -1, -1);
    align_to(1'b0);
    xfer(8'h03, -1, -1);
    align_to(1'b1);
    xfer(8'h07, 100, -1);
    align_to(1'b0);
    xfer(8'h04, -1, 8'h40);
    align_to(1'b0);
    xfer(8'h05, -1, -1);
    align_to(1'b1);
    xfer(8'hFF, 37, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
